// File: rtl/sync_fifo_ptr_ctrl.sv
// sync_fifo_ptr_ctrl: single-clock FIFO pointer and status controller.
// Keeps binary write/read pointers with one extra wrap bit, plus registered
// Gray copies for downstream CDC/debug logic. From these it derives the RAM
// addresses, full/empty, almost-full/almost-empty and the fill count.
// Optional macro SYNC_FIFO_PTR_ERR_EN enables the sticky overflow/underflow
// flags. Without it those outputs are tied low and err_clr is ignored.
module sync_fifo_ptr_ctrl #(
  parameter int PTR_WIDTH  = 4,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wen,
  input  logic                 ren,
  input  logic                 err_clr,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH-1:0] raddr,
  output logic [PTR_WIDTH:0]   wptr_bin,
  output logic [PTR_WIDTH:0]   rptr_bin,
  output logic [PTR_WIDTH:0]   wptr_gray,
  output logic [PTR_WIDTH:0]   rptr_gray,
  output logic [PTR_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [PTR_WIDTH:0] ONE        = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0] AFULL_CNT  = AFULL_LVL[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AEMPTY_CNT = AEMPTY_LVL[PTR_WIDTH:0];

  logic               wa;
  logic               ra;
  logic [PTR_WIDTH:0] wptr_nxt;
  logic [PTR_WIDTH:0] rptr_nxt;

  // Accept decisions use only the registered flags, so a rejected op never moves a pointer.
  always_comb begin
    wa       = wen & ~full;
    ra       = ren & ~empty;
    wptr_nxt = wptr_bin + ONE;
    rptr_nxt = rptr_bin + ONE;
  end

  // Write pointer: Gray is loaded from the incremented binary, so both change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_bin  <= '0;
      wptr_gray <= '0;
    end else if (wa) begin
      wptr_bin  <= wptr_nxt;
      wptr_gray <= wptr_nxt ^ (wptr_nxt >> 1);
    end
  end

  // Read pointer, mirroring the write side.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
    end else if (ra) begin
      rptr_bin  <= rptr_nxt;
      rptr_gray <= rptr_nxt ^ (rptr_nxt >> 1);
    end
  end

  // Status is purely combinational from the registered pointers.
  always_comb begin
    waddr        = wptr_bin[PTR_WIDTH-1:0];
    raddr        = rptr_bin[PTR_WIDTH-1:0];
    count        = wptr_bin - rptr_bin;
    empty        = (wptr_bin == rptr_bin);
    full         = (wptr_bin[PTR_WIDTH] != rptr_bin[PTR_WIDTH]) &&
                   (wptr_bin[PTR_WIDTH-1:0] == rptr_bin[PTR_WIDTH-1:0]);
    almost_full  = (count >= AFULL_CNT);
    almost_empty = (count <= AEMPTY_CNT);
  end

`ifdef SYNC_FIFO_PTR_ERR_EN
  // Sticky error flags: a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wen & full)
        overflow <= 1'b1;
      else if (err_clr)
        overflow <= 1'b0;
      if (ren & empty)
        underflow <= 1'b1;
      else if (err_clr)
        underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ptr_ctrl.sv
// tb_sync_fifo_ptr_ctrl: directed bench with a scoreboard queue for sync_fifo_ptr_ctrl.
// One instance runs the default thresholds. A second instance runs with
// AFULL_LVL=16 and AEMPTY_LVL=0, and both are driven by the same stimulus.
module tb_sync_fifo_ptr_ctrl;

  logic clk;
  logic rst;
  logic wen;
  logic ren;
  logic err_clr;

  logic [3:0] waddr, raddr, t_waddr, t_raddr;
  logic [4:0] wptr_bin, rptr_bin, wptr_gray, rptr_gray, count;
  logic [4:0] t_wptr_bin, t_rptr_bin, t_wptr_gray, t_rptr_gray, t_count;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic t_full, t_empty, t_almost_full, t_almost_empty, t_overflow, t_underflow;

  typedef struct {
    logic [4:0] wb, rb, wg, rg, cnt;
    logic       f, e, af, ae, ov, un, af2, ae2;
  } exp_t;

  exp_t sb_q[$];

  int mw, mr;
  bit movf, munf;
  int n_assert = 0;
  int n_fail   = 0;

  sync_fifo_ptr_ctrl #(.PTR_WIDTH(4), .AFULL_LVL(14), .AEMPTY_LVL(2)) dut (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren), .err_clr(err_clr),
    .waddr(waddr), .raddr(raddr), .wptr_bin(wptr_bin), .rptr_bin(rptr_bin),
    .wptr_gray(wptr_gray), .rptr_gray(rptr_gray), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_ptr_ctrl #(.PTR_WIDTH(4), .AFULL_LVL(16), .AEMPTY_LVL(0)) dut_thr (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren), .err_clr(err_clr),
    .waddr(t_waddr), .raddr(t_raddr), .wptr_bin(t_wptr_bin), .rptr_bin(t_rptr_bin),
    .wptr_gray(t_wptr_gray), .rptr_gray(t_rptr_gray), .count(t_count),
    .full(t_full), .empty(t_empty), .almost_full(t_almost_full),
    .almost_empty(t_almost_empty), .overflow(t_overflow), .underflow(t_underflow)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] bv;
    logic [4:0] g;
    bv = b[4:0];
    for (int i = 0; i < 5; i++)
      g[i] = (i == 4) ? bv[i] : (bv[i] ^ bv[i+1]);
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model, and queue the expected post-edge state.
  task automatic apply_stimulus(input bit r, input bit w, input bit rd, input bit clr);
    exp_t e;
    int   cnt;
    bit   wa, ra;
    rst = r; wen = w; ren = rd; err_clr = clr;
    cnt = (mw - mr + 32) % 32;
    if (r) begin
      mw = 0; mr = 0; movf = 0; munf = 0;
    end else begin
      wa = w && (cnt != 16);
      ra = rd && (cnt != 0);
      if (w && cnt == 16) movf = 1;
      else if (clr) movf = 0;
      if (rd && cnt == 0) munf = 1;
      else if (clr) munf = 0;
      if (wa) mw = (mw + 1) % 32;
      if (ra) mr = (mr + 1) % 32;
    end
    cnt   = (mw - mr + 32) % 32;
    e.wb  = mw[4:0];
    e.rb  = mr[4:0];
    e.wg  = to_gray(mw);
    e.rg  = to_gray(mr);
    e.cnt = cnt[4:0];
    e.f   = (cnt == 16);
    e.e   = (cnt == 0);
    e.af  = (cnt >= 14);
    e.ae  = (cnt <= 2);
    e.af2 = (cnt == 16);
    e.ae2 = (cnt == 0);
`ifdef SYNC_FIFO_PTR_ERR_EN
    e.ov  = movf;
    e.un  = munf;
`else
    e.ov  = 1'b0;
    e.un  = 1'b0;
`endif
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  // Pop the oldest expectation and compare every status output against it.
  task automatic check_output();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    check("wptr_bin", 32'(wptr_bin), 32'(e.wb));
    check("rptr_bin", 32'(rptr_bin), 32'(e.rb));
    check("wptr_gray", 32'(wptr_gray), 32'(e.wg));
    check("rptr_gray", 32'(rptr_gray), 32'(e.rg));
    check("waddr", 32'(waddr), 32'(e.wb[3:0]));
    check("raddr", 32'(raddr), 32'(e.rb[3:0]));
    check("count", 32'(count), 32'(e.cnt));
    check("full", 32'(full), 32'(e.f));
    check("empty", 32'(empty), 32'(e.e));
    check("almost_full", 32'(almost_full), 32'(e.af));
    check("almost_empty", 32'(almost_empty), 32'(e.ae));
    check("overflow", 32'(overflow), 32'(e.ov));
    check("underflow", 32'(underflow), 32'(e.un));
    check("thr_almost_full", 32'(t_almost_full), 32'(e.af2));
    check("thr_almost_empty", 32'(t_almost_empty), 32'(e.ae2));
    check("thr_count", 32'(t_count), 32'(e.cnt));
  endtask

  // Directed sequence of FIFO scenarios.
  initial begin
    mw = 0; mr = 0; movf = 0; munf = 0;
    rst = 1'b1; wen = 1'b0; ren = 1'b0; err_clr = 1'b0;

    // Reset held two cycles with both requests active.
    apply_stimulus(1, 1, 1, 0);
    apply_stimulus(1, 1, 1, 0);

    // Fill from empty to full.
    for (int i = 0; i < 16; i++) apply_stimulus(0, 1, 0, 0);
    check("fill_wptr_bin", 32'(wptr_bin), 32'h10);
    check("fill_wptr_gray", 32'(wptr_gray), 32'h18);

    // Overflow attempt, then clear; then an error together with a clear.
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 1);

    // Drain to empty, then underflow, then clear.
    for (int i = 0; i < 16; i++) apply_stimulus(0, 0, 1, 0);
    apply_stimulus(0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 1);

    // Simultaneous traffic at count 5 across pointer wrap.
    for (int i = 0; i < 5; i++) apply_stimulus(0, 1, 0, 0);
    for (int i = 0; i < 40; i++) apply_stimulus(0, 1, 1, 0);

    // Simultaneous at full leaves count 15.
    for (int i = 0; i < 11; i++) apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 1, 1, 0);

    // Simultaneous at empty leaves count 1.
    for (int i = 0; i < 15; i++) apply_stimulus(0, 0, 1, 0);
    apply_stimulus(0, 1, 1, 0);

    // Reset in the middle of traffic discards everything.
    for (int i = 0; i < 6; i++) apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ptr_ctrl.md
Name: sync_fifo_ptr_ctrl

Overview:
Single-clock FIFO pointer and status controller; generalises the separate write/read pointer blocks into one unit. Holds binary write/read pointers (one extra wrap bit) and registered Gray copies, and derives RAM addresses, full/empty, programmable almost-full/almost-empty and fill count. Sits between the FIFO user handshake and a dual-port RAM; the Gray outputs feed downstream CDC/debug logic glitch-free.

Parameters:
PTR_WIDTH, 4, address bits; DEPTH = 2**PTR_WIDTH entries; pointers are PTR_WIDTH+1 bits
AFULL_LVL, 14, almost_full asserts when count >= AFULL_LVL (legal 1..DEPTH)
AEMPTY_LVL, 2, almost_empty asserts when count <= AEMPTY_LVL (legal 0..DEPTH-1)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous reset, active-high
wen  input  1  write request
ren  input  1  read request
err_clr  input  1  clears sticky error flags
waddr  output  PTR_WIDTH  RAM write address = wptr_bin[PTR_WIDTH-1:0]
raddr  output  PTR_WIDTH  RAM read address = rptr_bin[PTR_WIDTH-1:0]
wptr_bin  output  PTR_WIDTH+1  binary write pointer (registered)
rptr_bin  output  PTR_WIDTH+1  binary read pointer (registered)
wptr_gray  output  PTR_WIDTH+1  Gray write pointer (registered)
rptr_gray  output  PTR_WIDTH+1  Gray read pointer (registered)
count  output  PTR_WIDTH+1  fill level 0..DEPTH
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
almost_full  output  1  count >= AFULL_LVL
almost_empty  output  1  count <= AEMPTY_LVL
overflow  output  1  sticky: write requested while full
underflow  output  1  sticky: read requested while empty

Behaviour:
- Reset (rst=1 at clk edge): all pointers (bin and Gray) = 0, overflow = underflow = 0; hence count=0, empty=1, full=0, almost_empty=1, almost_full=0 (for AFULL_LVL>0). rst has priority over every other input.
- Write accepted (wa) = wen & ~full; read accepted (ra) = ren & ~empty; both evaluated on current registered flags.
- wa: wptr_bin <= wptr_bin+1 (modulo 2**(PTR_WIDTH+1), wraps to 0 after all-ones). ra: same for rptr_bin.
- Gray registers are loaded from the NEXT binary value: wptr_gray <= nxt ^ (nxt>>1); Gray and binary change on the same edge, Gray differs by exactly one bit per increment, including wrap.
- full = (wptr_bin[MSB] != rptr_bin[MSB]) & (lower PTR_WIDTH bits equal); empty = (wptr_bin == rptr_bin). Flags, count, almost_* are combinational from registered pointers: visible the cycle after the accepted op (latency 1).
- count = wptr_bin - rptr_bin, PTR_WIDTH+1 bit unsigned.
- Simultaneous wen&ren: not full, not empty -> both advance, count unchanged. Full -> read only (write rejected, flags overflow). Empty -> write only (read rejected, flags underflow).
- Rejected ops never move pointers.
- err_clr clears overflow/underflow; a new error in the same cycle as err_clr wins (flag stays/sets 1).
- Reset mid-stream discards contents; no partial state survives.

Optional Feature:
SYNC_FIFO_PTR_ERR_EN. Defined: overflow/underflow sticky logic as above. Undefined: overflow and underflow tied to 0, err_clr ignored, no error registers synthesised; all other behaviour identical.

Test Plan:
- Reset: assert rst 2 cycles with wen=ren=1 -> pointers 0, empty=1, full=0, count=0, no pointer movement.
- Fill: 16 writes from empty (PTR_WIDTH=4) -> count 1..16, almost_full rises when count=14, full=1 after 16th, wptr_bin=5'b10000, wptr_gray=5'b11000, waddr=0.
- Overflow: at full, wen=1, ren=0 one cycle -> wptr unchanged, overflow=1 (macro on) / 0 (macro off); err_clr=1 -> overflow=0 next cycle.
- Drain and underflow: 16 reads from full -> empty=1, almost_empty rises at count=2; extra ren -> rptr unchanged, underflow=1.
- Simultaneous: at count=5 wen=ren=1 for 40 cycles -> count stays 5, both pointers wrap past 31->0, every Gray step single-bit change; at full wen=ren=1 -> count 15; at empty wen=ren=1 -> count 1.
- Threshold params: AFULL_LVL=16, AEMPTY_LVL=0 -> almost_full tracks full, almost_empty tracks empty exactly.
